// File: rtl/led_mon_pkg.sv
// Shared types and constants for the LED ring monitor.
// Optional feature macro: LED_MON_BIDIR_EN (reverse rotation accepted as legal).
package led_mon_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_BAD_PATTERN = 2'd1;
    localparam logic [1:0] ERR_BAD_JUMP    = 2'd2;

endpackage

// File: rtl/led_onehot_enc.sv
// Combinational one-hot check and 3-bit index encode of the LED bus.
module led_onehot_enc
    import led_mon_pkg::*;
(
    input  logic [LED_W-1:0] vec,
    output logic             onehot,
    output logic [2:0]       idx
);

    // Flag exactly-one-set and report the position of the set bit.
    always_comb begin
        onehot = $onehot(vec);
        idx    = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (vec[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/led_ring_monitor.sv
// Receive-side checker for the rotating one-hot LED bus.
// Optional feature macro: LED_MON_BIDIR_EN adds reverse steps and the dir output.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | waiting for first one-hot sample to lock onto
// TRACK | locked; each sample is a hold, a legal step, or a violation
// ERROR | violation seen; outputs frozen until clr
module led_ring_monitor
    import led_mon_pkg::*;
#(
    parameter int LAP_W     = 8,
    parameter int STALL_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] led,
    input  logic             clr,
    output logic [2:0]       pos,
    output logic             pos_vld,
    output logic             step,
    output logic             lap,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             stall,
    output logic             err,
`ifdef LED_MON_BIDIR_EN
    output logic             dir,
`endif
    output logic [1:0]       err_code
);

    localparam int              CNT_W    = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] STALL_TC = CNT_W'(STALL_MAX);

    state_t             state, state_nxt;
    logic [LED_W-1:0]   prev, prev_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [2:0]         pos_nxt;
    logic               pos_vld_nxt, step_nxt, lap_nxt, stall_nxt, err_nxt;
    logic [LAP_W-1:0]   lap_cnt_nxt;
    logic [1:0]         code_nxt;
    logic               onehot;
    logic [2:0]         idx;
    logic [LED_W-1:0]   fwd;
`ifdef LED_MON_BIDIR_EN
    logic [LED_W-1:0]   rev;
    logic               dir_nxt;
`endif

    led_onehot_enc u_enc (
        .vec    (led),
        .onehot (onehot),
        .idx    (idx)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            prev     <= '0;
            cnt      <= '0;
            pos      <= '0;
            pos_vld  <= 1'b0;
            step     <= 1'b0;
            lap      <= 1'b0;
            lap_cnt  <= '0;
            stall    <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
`ifdef LED_MON_BIDIR_EN
            dir      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            cnt      <= cnt_nxt;
            pos      <= pos_nxt;
            pos_vld  <= pos_vld_nxt;
            step     <= step_nxt;
            lap      <= lap_nxt;
            lap_cnt  <= lap_cnt_nxt;
            stall    <= stall_nxt;
            err      <= err_nxt;
            err_code <= code_nxt;
`ifdef LED_MON_BIDIR_EN
            dir      <= dir_nxt;
`endif
        end
    end

    // Next-state and next-output decode; clr overrides the sample.
    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        cnt_nxt     = cnt;
        pos_nxt     = pos;
        pos_vld_nxt = pos_vld;
        step_nxt    = 1'b0;
        lap_nxt     = 1'b0;
        lap_cnt_nxt = lap_cnt;
        stall_nxt   = stall;
        err_nxt     = err;
        code_nxt    = err_code;
        fwd         = {prev[LED_W-2:0], prev[LED_W-1]};
        cnt_inc     = (cnt == STALL_TC) ? cnt : cnt + 1'b1;
`ifdef LED_MON_BIDIR_EN
        rev         = {prev[0], prev[LED_W-1:1]};
        dir_nxt     = dir;
`endif
        if (clr) begin
            state_nxt   = INIT;
            err_nxt     = 1'b0;
            code_nxt    = ERR_NONE;
            lap_cnt_nxt = '0;
            stall_nxt   = 1'b0;
            cnt_nxt     = '0;
            pos_vld_nxt = 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (onehot) begin
                        state_nxt   = TRACK;
                        prev_nxt    = led;
                        pos_nxt     = idx;
                        pos_vld_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_BAD_PATTERN;
                    end
                end
                TRACK: begin
                    if (!onehot || (led != prev && led != fwd
`ifdef LED_MON_BIDIR_EN
                                    && led != rev
`endif
                        )) begin
                        state_nxt   = ERROR;
                        err_nxt     = 1'b1;
                        code_nxt    = onehot ? ERR_BAD_JUMP : ERR_BAD_PATTERN;
                        pos_vld_nxt = 1'b0;
                        stall_nxt   = 1'b0;
                        cnt_nxt     = '0;
                    end else if (led == prev) begin
                        cnt_nxt   = cnt_inc;
                        stall_nxt = (cnt_inc == STALL_TC);
                    end else begin
                        step_nxt  = 1'b1;
                        prev_nxt  = led;
                        pos_nxt   = idx;
                        cnt_nxt   = '0;
                        stall_nxt = 1'b0;
`ifdef LED_MON_BIDIR_EN
                        dir_nxt   = (led != fwd);
                        if ((led == fwd && prev[LED_W-1]) || (led != fwd && prev[0])) begin
`else
                        if (prev[LED_W-1]) begin
`endif
                            lap_nxt     = 1'b1;
                            lap_cnt_nxt = lap_cnt + 1'b1;
                        end
                    end
                end
                ERROR: begin
                end
                default: state_nxt = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_led_ring_monitor.sv
// Self-checking bench: directed sequences plus randomized traffic against a behavioural model.
module tb_led_ring_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led = 8'h00;
    logic       clr = 1'b0;
    logic [2:0] pos;
    logic       pos_vld, step, lap, stall, err;
    logic [7:0] lap_cnt;
    logic [1:0] err_code;
    logic       dir;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    led_ring_monitor #(.LAP_W(8), .STALL_MAX(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .led      (led),
        .clr      (clr),
        .pos      (pos),
        .pos_vld  (pos_vld),
        .step     (step),
        .lap      (lap),
        .lap_cnt  (lap_cnt),
        .stall    (stall),
        .err      (err),
`ifdef LED_MON_BIDIR_EN
        .dir      (dir),
`endif
        .err_code (err_code)
    );
`ifndef LED_MON_BIDIR_EN
    assign dir = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = waiting, 1 = locked, 2 = faulted.
    int         m_mode  = 0;
    logic [7:0] m_prev  = 8'h00;
    int         m_pos   = 0;
    int         m_hold  = 0;
    bit         m_vld = 0, m_step = 0, m_lap = 0, m_stall = 0, m_err = 0, m_dir = 0;
    logic [7:0] m_lapcnt = 8'h00;
    int         m_code  = 0;

    function automatic int idx_of(input logic [7:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic fault(input int code);
        m_mode  = 2;
        m_err   = 1;
        m_code  = code;
        m_vld   = 0;
        m_stall = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        int k;
        if (!rst) begin
            m_mode = 0; m_prev = 8'h00; m_pos = 0; m_hold = 0; m_vld = 0; m_step = 0;
            m_lap = 0; m_stall = 0; m_err = 0; m_dir = 0; m_lapcnt = 8'h00; m_code = 0;
        end else begin
            k = idx_of(led);
            m_step = 0;
            m_lap  = 0;
            if (clr) begin
                m_mode = 0; m_err = 0; m_code = 0; m_lapcnt = 8'h00;
                m_stall = 0; m_hold = 0; m_vld = 0;
            end else if (m_mode == 0) begin
                if (k < 0) fault(1);
                else begin
                    m_mode = 1; m_prev = led; m_pos = k; m_vld = 1; m_hold = 0;
                end
            end else if (m_mode == 1) begin
                if (k < 0) fault(1);
                else if (led == m_prev) begin
                    if (m_hold < 16) m_hold++;
                    m_stall = (m_hold == 16);
                end else if (k == (m_pos + 1) % 8) begin
                    m_step = 1; m_lap = (m_pos == 7); m_dir = 0;
                    if (m_lap) m_lapcnt++;
                    m_pos = k; m_prev = led; m_hold = 0; m_stall = 0;
                end
`ifdef LED_MON_BIDIR_EN
                else if (k == (m_pos + 7) % 8) begin
                    m_step = 1; m_lap = (m_pos == 0); m_dir = 1;
                    if (m_lap) m_lapcnt++;
                    m_pos = k; m_prev = led; m_hold = 0; m_stall = 0;
                end
`endif
                else fault(2);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pos",      int'(pos),      m_pos);
            chk("pos_vld",  int'(pos_vld),  int'(m_vld));
            chk("step",     int'(step),     int'(m_step));
            chk("lap",      int'(lap),      int'(m_lap));
            chk("lap_cnt",  int'(lap_cnt),  int'(m_lapcnt));
            chk("stall",    int'(stall),    int'(m_stall));
            chk("err",      int'(err),      int'(m_err));
            chk("err_code", int'(err_code), m_code);
`ifdef LED_MON_BIDIR_EN
            chk("dir",      int'(dir),      int'(m_dir));
`endif
        end
    end

    task automatic drive(input logic [7:0] l, input logic c);
        led = l;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] cur;

    initial begin
        #2 rst = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pos_vld", int'(pos_vld), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_lap_cnt", int'(lap_cnt), 0);
        rst = 1'b1;

        // Lock and hold
        repeat (3) drive(8'h01, 0);
        chk("lock_pos_vld", int'(pos_vld), 1);
        chk("lock_pos", int'(pos), 0);
        chk("lock_step", int'(step), 0);
        chk("lock_err", int'(err), 0);
        chk("lock_stall", int'(stall), 0);

        // One full lap
        cur = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            cur = {cur[6:0], cur[7]};
            drive(cur, 0);
            chk("lap_step", int'(step), 1);
            chk("lap_pos", int'(pos), i % 8);
            chk("lap_pulse", int'(lap), (i == 8) ? 1 : 0);
        end
        chk("lap_cnt_1", int'(lap_cnt), 1);

        // Stall at 04
        drive(8'h02, 0);
        drive(8'h04, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(8'h04, 0);
            chk("stall_hold", int'(stall), (i == 16) ? 1 : 0);
        end
        drive(8'h08, 0);
        chk("stall_clear", int'(stall), 0);
        chk("stall_step", int'(step), 1);
        chk("stall_pos", int'(pos), 3);

        // Bad pattern, sticky
        drive(8'h00, 1);
        drive(8'h04, 0);
        drive(8'h06, 0);
        chk("badpat_err", int'(err), 1);
        chk("badpat_code", int'(err_code), 1);
        chk("badpat_vld", int'(pos_vld), 0);
        drive(8'h08, 0);
        chk("sticky_code", int'(err_code), 1);

        // Bad jump, then clr
        drive(8'h00, 1);
        drive(8'h04, 0);
        drive(8'h20, 0);
        chk("jump_code", int'(err_code), 2);
        drive(8'h10, 1);
        chk("clr_err", int'(err), 0);
        chk("clr_lap_cnt", int'(lap_cnt), 0);
        drive(8'h10, 0);
        chk("relock_pos", int'(pos), 4);
        chk("relock_vld", int'(pos_vld), 1);

        // Reverse 01 -> 80
        drive(8'h00, 1);
        drive(8'h01, 0);
        drive(8'h80, 0);
`ifdef LED_MON_BIDIR_EN
        chk("rev_step", int'(step), 1);
        chk("rev_dir", int'(dir), 1);
        chk("rev_pos", int'(pos), 7);
        chk("rev_lap_cnt", int'(lap_cnt), 1);
        chk("rev_err", int'(err), 0);
`else
        chk("rev_code", int'(err_code), 2);
`endif

        // Randomized traffic
        cur = 8'h01;
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 8) begin
                rst = 1'b0;
                @(negedge clk);
                #1 rst = 1'b1;
                continue;
            end
            if ($countones(cur) != 1) cur = 8'h01 << $urandom_range(0, 7);
            if (m_mode == 2 && r < 150) drive(cur, 1);
            else if (r < 20) drive(cur, 1);
            else if (r < 420) begin
                cur = {cur[6:0], cur[7]};
                drive(cur, 0);
            end else if (r < 560) begin
                cur = {cur[0], cur[7:1]};
                drive(cur, 0);
            end else if (r < 600) begin
                repeat ($urandom_range(10, 20)) drive(cur, 0);
            end else if (r < 620) begin
                cur = 8'h01 << $urandom_range(0, 7);
                drive(cur, 0);
            end else if (r < 635) begin
                cur = 8'($urandom);
                drive(cur, 0);
            end else drive(cur, 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
